// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (dirty flag + youngest writer's ROB tag).
// Each operand read port forwards from same-cycle commit or from the ROB before reporting a dependency.
module reg_status_file #(
  parameter  int XLEN    = 32,
  parameter  int NREG    = 32,
  parameter  int ROB_BIT = 4,
  parameter  int NRD     = 2,
  localparam int RIDX    = $clog2(NREG),
  localparam int CW      = $clog2(NREG + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    commit_valid,
  input  logic [RIDX-1:0]         commit_rd,
  input  logic [XLEN-1:0]         commit_data,
  input  logic [ROB_BIT-1:0]      commit_tag,
  input  logic                    issue_valid,
  input  logic [RIDX-1:0]         issue_rd,
  input  logic [ROB_BIT-1:0]      issue_tag,
  input  logic [NRD*RIDX-1:0]     rd_id,
  output logic [NRD*XLEN-1:0]     rd_val,
  output logic [NRD-1:0]          rd_dep_valid,
  output logic [NRD*ROB_BIT-1:0]  rd_dep_tag,
  output logic [NRD*ROB_BIT-1:0]  rob_query_tag,
  input  logic [NRD-1:0]          rob_query_ready,
  input  logic [NRD*XLEN-1:0]     rob_query_value,
  output logic [CW-1:0]           dirty_count,
  output logic                    all_clean
);

  logic [XLEN-1:0]    regs [NREG];
  logic [ROB_BIT-1:0] tags [NREG];
  logic [NREG-1:0]    dirty;

  logic commit_en, commit_clr, issue_en, cnt_inc, cnt_dec;

  assign commit_en  = commit_valid && (commit_rd != '0);
  assign commit_clr = commit_en && dirty[commit_rd] && (tags[commit_rd] == commit_tag);
  assign issue_en   = issue_valid && (issue_rd != '0);
  // A commit clear overridden by a same-register issue leaves the count unchanged.
  assign cnt_inc    = issue_en && !dirty[issue_rd];
  assign cnt_dec    = commit_clr && !(issue_en && (issue_rd == commit_rd));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
      dirty       <= '0;
      dirty_count <= '0;
    end else if (rdy_in) begin
      if (commit_en)
        regs[commit_rd] <= commit_data;
      if (flush_in) begin
        for (int i = 0; i < NREG; i++)
          tags[i] <= '0;
        dirty       <= '0;
        dirty_count <= '0;
      end else begin
        if (commit_clr) begin
          dirty[commit_rd] <= 1'b0;
          tags[commit_rd]  <= '0;
        end
        // Later assignment lets the issue win over a same-register commit clear.
        if (issue_en) begin
          dirty[issue_rd] <= 1'b1;
          tags[issue_rd]  <= issue_tag;
        end
        dirty_count <= dirty_count + CW'(cnt_inc) - CW'(cnt_dec);
      end
    end
  end

  assign all_clean = (dirty_count == '0);

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [RIDX-1:0]    id;
    logic [XLEN-1:0]    val;
    logic               dep;
    logic [ROB_BIT-1:0] dtag;

    assign id = rd_id[p*RIDX +: RIDX];

    always_comb begin
      val  = regs[id];
      dep  = 1'b0;
      dtag = '0;
      if (id == '0) begin
        val = '0;
      end else if (dirty[id]) begin
        if (commit_valid && (commit_tag == tags[id]))
          val = commit_data;
        else if (rob_query_ready[p])
          val = rob_query_value[p*XLEN +: XLEN];
        else begin
          dep  = 1'b1;
          dtag = tags[id];
        end
      end
    end

    assign rd_val[p*XLEN +: XLEN]          = val;
    assign rd_dep_valid[p]                 = dep;
    assign rd_dep_tag[p*ROB_BIT +: ROB_BIT] = dtag;
    assign rob_query_tag[p*ROB_BIT +: ROB_BIT] = tags[id];
  end

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Parametrised architectural register file with rename-status tracking for the out-of-order core. It sits between decoder, ROB and commit logic. It holds committed register values, and per register a dirty flag and the ROB tag of the youngest in-flight writer. It serves NRD independent operand read ports, each with ROB-value forwarding and same-cycle commit bypass, and reports a live count of renamed registers.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count (power of two, ≥2); RIDX = $clog2(NREG)
- ROB_BIT, 4, ROB tag width
- NRD, 2, number of operand read ports
- CW = $clog2(NREG+1), dirty-counter width (derived)

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset; one clock; asynchronous, active-low
- rdy_in  in  1  pause when low
- flush_in  in  1  ROB clear-up (mispredict)
- commit_valid  in  1  ROB commit strobe
- commit_rd  in  RIDX  committed destination
- commit_data  in  XLEN  committed value
- commit_tag  in  ROB_BIT  committing ROB entry
- issue_valid  in  1  decoder rename strobe
- issue_rd  in  RIDX  renamed destination
- issue_tag  in  ROB_BIT  allocated ROB entry
- rd_id  in  NRD*RIDX  source register per port (port p at bits [p*RIDX +: RIDX])
- rd_val  out  NRD*XLEN  operand value per port
- rd_dep_valid  out  NRD  operand not yet available
- rd_dep_tag  out  NRD*ROB_BIT  producer tag; 0 when rd_dep_valid=0
- rob_query_tag  out  NRD*ROB_BIT  tag of current writer of rd_id[p] to ROB
- rob_query_ready  in  NRD  ROB entry has result
- rob_query_value  in  NRD*XLEN  ROB entry result
- dirty_count  out  CW  number of dirty registers
- all_clean  out  1  dirty_count == 0

## Operation
- State: regs[NREG], dirty[NREG], tag[NREG], dirty_count. Register 0 is never written and never dirty.
- Read port p (combinational, from current state; same-cycle issue NOT visible), priority order:
  1. rd_id==0 → val 0, dep_valid 0.
  2. dirty and commit_valid and commit_tag==tag[id] → val commit_data, dep_valid 0 (commit bypass).
  3. dirty and rob_query_ready[p] → val rob_query_value[p], dep_valid 0.
  4. dirty → val don't-care (drive regs[id]), dep_valid 1, dep_tag tag[id].
  5. else → val regs[id], dep_valid 0.
- rob_query_tag[p] = tag[rd_id[p]] unconditionally.
- Clock edge, rdy_in=1, flush_in=0:
  - commit_valid and commit_rd≠0: regs[commit_rd] ← commit_data; if dirty and tag[commit_rd]==commit_tag, clear dirty and tag.
  - issue_valid and issue_rd≠0: dirty ← 1, tag ← issue_tag. Issue wins over a same-cycle commit clear on the same register.
  - dirty_count ← population of the resulting dirty[] (+1 on issue to a clean reg, −1 on a matching commit clear, net 0 if both apply to the same reg).
- flush_in=1, rdy_in=1: all dirty and tags ← 0, dirty_count ← 0. Same-cycle commit still writes regs (the flushing instruction's rd). Issue is ignored.
- rdy_in=0: no state change; read outputs stay live.
- Commits with rd=0 and issues with rd=0 are no-ops.

## Timing
- Reads: zero latency, combinational from rd_id, ROB inputs and commit inputs.
- Writes visible on reads the cycle after the edge.
- Reset (asynchronous assert, released synchronously to clk_in): regs, dirty and tags ← 0; dirty_count=0; all_clean=1. With rd_id=0, rd_val=0 and rd_dep_valid=0. Reset mid-operation discards all rename state immediately, without waiting for a clock.
- all_clean is combinational from the registered dirty_count.
- Boundary: all NREG−1 registers dirty → dirty_count=NREG−1. Tag value 0 is a legal ROB entry; dirty[], not the tag value, determines the dependency.

## Test plan
- Reset mid-run with x5 dirty: assert rst_n_in low between edges → dirty_count=0, all_clean=1 immediately; rd_id=5 reads 0, no dep.
- Issue x5 tag 3; next cycle read x5 with rob_query_ready=0 → dep_valid=1, dep_tag=3, rob_query_tag=3. Then rob_query_ready=1, value 0xAB → val 0xAB, dep_valid 0.
- Commit x5 tag 3 data 0x1234 while reading x5 on both ports → same-cycle val 0x1234, no dep. Next cycle x5 clean, regs=0x1234, dirty_count=0.
- Issue x7 tag 9, then x7 tag 10; commit x7 tag 9 data 0x55 → regs[7]=0x55, x7 still dirty with tag 10, dirty_count=1. Also check a same-cycle commit of tag 10 together with an issue of x7 tag 11 → dirty, tag 11.
- Dirty x1..x4, then flush with commit x2 data 0x77 and issue x6 → all clean, regs[2]=0x77, x6 not dirty, dirty_count=0.
- rdy_in=0 with issue/commit asserted → no state change. Issue/commit to x0 → x0 reads 0, dirty_count unchanged.
